lpif_txrx_x2_asym1_tx_sched: RTL and testbench
==============================================

LPIF_TXRX_X2_ASYM1_TX_SCHED -- requirements
Module: lpif_txrx_x2_asym1_tx_sched

Interface
REQ-001 Parameter STB_INTERVAL, default 8: strobe period in clk_wr cycles; legal range 2..255.
REQ-002 Parameter ONLINE_DLY, default 4: settle cycles after tx_online rises, before alignment starts; legal range 1..255.
REQ-003 clk_wr  input  1  sole clock; all state is on the rising edge.
REQ-004 rst_wr_n  input  1  asynchronous active-low reset.
REQ-005 tx_online  input  1  link-up qualifier from the AIB adapter.
REQ-006 m_gen2_mode  input  1  must be 0 (Gen1-only full rate); monitored only.
REQ-007 up_data  input  75  payload word from the logic link.
REQ-008 up_valid  input  1  up_data is valid.
REQ-009 up_ready  output  1  scheduler accepts up_data this cycle.
REQ-010 tx_downstream_data  output  75  word to the x2 asym1 concat TX datapath.
REQ-011 tx_stb_userbit  output  1  strobe bit, placed at bit 1 of each channel.
REQ-012 tx_mrk_userbit  output  1 ([0:0])  marker bit, placed at bit 39 of each channel.
REQ-013 sched_state  output  2  encoded FSM state.
REQ-014 idle_cnt  output  16  idle words inserted while ACTIVE; saturating.
REQ-015 err_gen2  output  1  sticky; m_gen2_mode seen high while tx_online = 1.

Function
REQ-016 FSM states and encodings: OFFLINE = 0, SETTLE = 1, ALIGN = 2, ACTIVE = 3.
REQ-017 OFFLINE -> SETTLE on tx_online = 1; settle_cnt loads 0.
REQ-018 SETTLE increments settle_cnt each cycle.
REQ-019 SETTLE -> ALIGN in the cycle settle_cnt = ONLINE_DLY-1.
REQ-020 ALIGN -> ACTIVE in the cycle stb_cnt = STB_INTERVAL-1, so ACTIVE begins on a strobe cycle.
REQ-021 tx_online = 0 in any state forces OFFLINE next cycle; this overrides every other transition.
REQ-022 stb_cnt, 8 bits: holds 0 in OFFLINE and SETTLE; in ALIGN and ACTIVE it counts 0..STB_INTERVAL-1 and wraps to 0.
REQ-023 tx_stb_userbit is registered and equals 1 in the cycle after stb_cnt = 0 in ALIGN or ACTIVE; it is 1 for one cycle in every STB_INTERVAL, otherwise 0.
REQ-024 The first strobe appears 1 cycle after entry to ALIGN.
REQ-025 tx_mrk_userbit is registered and equals 1 whenever the state of the previous cycle was ALIGN or ACTIVE (full rate: every word is a marker word); otherwise 0.
REQ-026 up_ready is combinational and equals (state == ACTIVE) && tx_online.
REQ-027 A transfer occurs when up_valid && up_ready.
REQ-028 tx_downstream_data is registered, latency 1: after a transfer it is the accepted up_data; otherwise it is all-zero (idle word).
REQ-029 Data, strobe and marker are aligned in the same output cycle.
REQ-030 idle_cnt increments when state == ACTIVE && !up_valid; it saturates at 16'hFFFF and clears only on reset.
REQ-031 When tx_online falls while up_valid = 1, up_ready drops in that same cycle and no data is accepted; the next output word is zero.
REQ-032 err_gen2 sets when m_gen2_mode && tx_online; it holds until reset; FSM behaviour is unaffected.

Reset
REQ-033 Asynchronous assertion of rst_wr_n gives: state OFFLINE, settle_cnt = 0, stb_cnt = 0, tx_downstream_data = 0, tx_stb_userbit = 0, tx_mrk_userbit = 0, idle_cnt = 0, err_gen2 = 0.
REQ-034 During and after reset up_ready = 0.
REQ-035 Reset asserted mid-ACTIVE discards any in-flight word.

Structure
REQ-036 Shared package lpif_tx_sched_pkg holds: state enum (2-bit), STB_INTERVAL/ONLINE_DLY defaults, data width constant 75.
REQ-037 Sub-module lpif_tx_stb_gen contains stb_cnt and strobe/marker registers; it takes en and wrap inputs.
REQ-038 The FSM, data register and counters stay in the top module.

Verification
REQ-039 Reset, then tx_online = 1 at cycle 0 (defaults) -> SETTLE for cycles 1-4, ALIGN at cycle 5, first tx_stb_userbit at cycle 6, ACTIVE at cycle 13 with up_ready = 1.
REQ-040 In ACTIVE, up_valid = 1 continuously, up_data = 75'h1_2345_6789_ABCD_EF01 -> same value on tx_downstream_data 1 cycle later; strobe period exactly 8; tx_mrk_userbit = 1 on every cycle.
REQ-041 In ACTIVE, up_valid = 0 for 20 cycles -> tx_downstream_data = 0 for those cycles and idle_cnt = 20.
REQ-042 tx_online dropped for 1 cycle mid-ACTIVE with up_valid = 1 -> up_ready = 0 in that cycle, OFFLINE next, strobe/marker 0; full re-sequence follows.
REQ-043 m_gen2_mode = 1 with tx_online = 1 for 1 cycle -> err_gen2 = 1 and stays 1 until rst_wr_n pulse; strobe timing unchanged.
REQ-044 STB_INTERVAL = 2, ONLINE_DLY = 1, and rst_wr_n asserted in ACTIVE -> all outputs 0 immediately; alternate-cycle strobes resume after re-sequence.

Source files
------------

// File: rtl/lpif_tx_sched_pkg.sv
// Shared definitions for the x2 asym1 TX scheduler: state encoding, default
// timing parameters and the payload width.
package lpif_tx_sched_pkg;

    localparam int DATA_W           = 75;
    localparam int STB_INTERVAL_DEF = 8;
    localparam int ONLINE_DLY_DEF   = 4;

    typedef enum logic [1:0] {
        ST_OFFLINE = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ALIGN   = 2'd2,
        ST_ACTIVE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/lpif_tx_stb_gen.sv
// Strobe/marker generator: free-running strobe counter while enabled, with
// registered strobe and marker user bits aligned to the data register.
module lpif_tx_stb_gen (
    input  logic       clk_wr,
    input  logic       rst_wr_n,
    input  logic       en,
    input  logic       wrap,
    output logic [7:0] stb_cnt,
    output logic       tx_stb_userbit,
    output logic [0:0] tx_mrk_userbit
);

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            stb_cnt        <= 8'd0;
            tx_stb_userbit <= 1'b0;
            tx_mrk_userbit <= 1'b0;
        end else begin
            if (!en || wrap) stb_cnt <= 8'd0;
            else             stb_cnt <= stb_cnt + 8'd1;
            tx_stb_userbit <= en && (stb_cnt == 8'd0);
            // Full rate: every word sent while aligned carries the marker.
            tx_mrk_userbit <= en;
        end
    end

endmodule

// File: rtl/lpif_txrx_x2_asym1_tx_sched.sv
// TX scheduler: sequences link bring-up (settle, strobe alignment) and then
// forwards payload words, inserting zero idle words when nothing is offered.
module lpif_txrx_x2_asym1_tx_sched
    import lpif_tx_sched_pkg::*;
#(
    parameter int STB_INTERVAL = STB_INTERVAL_DEF,
    parameter int ONLINE_DLY   = ONLINE_DLY_DEF
) (
    input  logic              clk_wr,
    input  logic              rst_wr_n,
    input  logic              tx_online,
    input  logic              m_gen2_mode,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] tx_downstream_data,
    output logic              tx_stb_userbit,
    output logic [0:0]        tx_mrk_userbit,
    output logic [1:0]        sched_state,
    output logic [15:0]       idle_cnt,
    output logic              err_gen2
);

    sched_state_e state, state_nxt;
    logic [7:0]   settle_cnt;
    logic [7:0]   stb_cnt;
    logic         stb_en;
    logic         stb_wrap;

    assign stb_en      = (state == ST_ALIGN) || (state == ST_ACTIVE);
    assign stb_wrap    = (stb_cnt == 8'(STB_INTERVAL - 1));
    assign up_ready    = (state == ST_ACTIVE) && tx_online;
    assign sched_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFFLINE: if (tx_online) state_nxt = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == 8'(ONLINE_DLY - 1)) state_nxt = ST_ALIGN;
            ST_ALIGN:   if (stb_wrap) state_nxt = ST_ACTIVE;
            ST_ACTIVE:  state_nxt = ST_ACTIVE;
            default:    state_nxt = ST_OFFLINE;
        endcase
        // Losing the link wins over any bring-up progress.
        if (!tx_online) state_nxt = ST_OFFLINE;
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state      <= ST_OFFLINE;
            settle_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            tx_downstream_data <= '0;
            idle_cnt           <= 16'd0;
            err_gen2           <= 1'b0;
        end else begin
            tx_downstream_data <= (up_valid && up_ready) ? up_data : '0;
            if ((state == ST_ACTIVE) && !up_valid && (idle_cnt != 16'hFFFF))
                idle_cnt <= idle_cnt + 16'd1;
            if (m_gen2_mode && tx_online)
                err_gen2 <= 1'b1;
        end
    end

    lpif_tx_stb_gen u_stb_gen (
        .clk_wr         (clk_wr),
        .rst_wr_n       (rst_wr_n),
        .en             (stb_en),
        .wrap           (stb_wrap),
        .stb_cnt        (stb_cnt),
        .tx_stb_userbit (tx_stb_userbit),
        .tx_mrk_userbit (tx_mrk_userbit)
    );

endmodule

// File: tb/tb_lpif_txrx_x2_asym1_tx_sched.sv
// Bench for the TX scheduler: two parameterisations share one stimulus and are
// checked every cycle against a timeline model, plus literal timing pins.
module tb_lpif_txrx_x2_asym1_tx_sched;
    import lpif_tx_sched_pkg::*;

    logic        clk_wr   = 1'b0;
    logic        rst_wr_n = 1'b1;
    logic        tx_online, m_gen2_mode, up_valid;
    logic [74:0] up_data;

    logic        up_ready [2];
    logic [74:0] dout     [2];
    logic        stb      [2];
    logic [0:0]  mrk      [2];
    logic [1:0]  st       [2];
    logic [15:0] idle     [2];
    logic        err      [2];

    int tests = 0;
    int fails = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_txrx_x2_asym1_tx_sched u_dut_def (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(tx_online),
        .m_gen2_mode(m_gen2_mode), .up_data(up_data), .up_valid(up_valid),
        .up_ready(up_ready[0]), .tx_downstream_data(dout[0]),
        .tx_stb_userbit(stb[0]), .tx_mrk_userbit(mrk[0]),
        .sched_state(st[0]), .idle_cnt(idle[0]), .err_gen2(err[0])
    );

    lpif_txrx_x2_asym1_tx_sched #(.STB_INTERVAL(2), .ONLINE_DLY(1)) u_dut_min (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(tx_online),
        .m_gen2_mode(m_gen2_mode), .up_data(up_data), .up_valid(up_valid),
        .up_ready(up_ready[1]), .tx_downstream_data(dout[1]),
        .tx_stb_userbit(stb[1]), .tx_mrk_userbit(mrk[1]),
        .sched_state(st[1]), .idle_cnt(idle[1]), .err_gen2(err[1])
    );

    task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    // Model: the state is a pure function of how many cycles the link has
    // been up (n), the settle delay D and the strobe interval S.
    int          md [2] = '{4, 1};
    int          ms [2] = '{8, 2};
    bit          ph [2];
    int          n  [2];
    logic [74:0] m_data [2];
    bit          m_stb [2], m_mrk [2], m_err [2];
    int          m_idle [2];

    function automatic logic [1:0] mstate(input int i);
        if (!ph[i])                 return 2'd0;
        if (n[i] < md[i])           return 2'd1;
        if (n[i] < md[i] + ms[i])   return 2'd2;
        return 2'd3;
    endfunction

    initial begin
        forever begin
            @(negedge clk_wr);
            for (int i = 0; i < 2; i++) begin
                if (!rst_wr_n) begin
                    ph[i] = 0; n[i] = 0; m_data[i] = '0; m_stb[i] = 0;
                    m_mrk[i] = 0; m_err[i] = 0; m_idle[i] = 0;
                    chk($sformatf("rst_state[%0d]", i), st[i], 0);
                    chk($sformatf("rst_ready[%0d]", i), up_ready[i], 0);
                    chk($sformatf("rst_data[%0d]", i), dout[i], 0);
                    chk($sformatf("rst_stb_mrk[%0d]", i), {stb[i], mrk[i]}, 0);
                    chk($sformatf("rst_idle_err[%0d]", i), {idle[i], err[i]}, 0);
                end else begin
                    logic [1:0] s;
                    bit act_al;
                    s = mstate(i);
                    chk($sformatf("state[%0d]", i), st[i], s);
                    chk($sformatf("ready[%0d]", i), up_ready[i], (s == 2'd3) && tx_online);
                    chk($sformatf("data[%0d]", i), dout[i], m_data[i]);
                    chk($sformatf("stb[%0d]", i), stb[i], m_stb[i]);
                    chk($sformatf("mrk[%0d]", i), mrk[i], m_mrk[i]);
                    chk($sformatf("idle[%0d]", i), idle[i], 16'(m_idle[i]));
                    chk($sformatf("err[%0d]", i), err[i], m_err[i]);
                    act_al    = (s == 2'd2) || (s == 2'd3);
                    m_stb[i]  = act_al && (((n[i] - md[i]) % ms[i]) == 0);
                    m_mrk[i]  = act_al;
                    m_data[i] = ((s == 2'd3) && tx_online && up_valid) ? up_data : '0;
                    if ((s == 2'd3) && !up_valid && m_idle[i] < 65535) m_idle[i]++;
                    if (m_gen2_mode && tx_online) m_err[i] = 1;
                    if (!tx_online)  ph[i] = 0;
                    else if (!ph[i]) begin ph[i] = 1; n[i] = 0; end
                    else             n[i]++;
                end
            end
        end
    end

    initial begin
        tx_online = 0; m_gen2_mode = 0; up_valid = 0; up_data = '0;
        #1 rst_wr_n = 0;
        repeat (3) @(posedge clk_wr);
        #1 rst_wr_n = 1;

        // Bring-up with defaults: cycle 0 is the first cycle with tx_online high.
        step(); tx_online = 1;
        repeat (5) step();
        @(negedge clk_wr); chk("align_c5", st[0], 2);
        step();
        @(negedge clk_wr); chk("first_stb_c6", stb[0], 1);
        repeat (7) step();
        up_valid = 1; up_data = 75'h1_2345_6789_ABCD_EF01;
        @(negedge clk_wr); chk("active_c13", st[0], 3); chk("ready_c13", up_ready[0], 1);
        step();
        @(negedge clk_wr);
        chk("data_c14", dout[0], 75'h1_2345_6789_ABCD_EF01);
        chk("stb_c14", stb[0], 1);
        repeat (7) step();
        @(negedge clk_wr); chk("stb_c21", stb[0], 0);
        step();
        @(negedge clk_wr); chk("stb_c22", stb[0], 1); chk("mrk_c22", mrk[0], 1);

        for (int k = 0; k < 6; k++) begin
            step();
            up_data = {11'(k + 1), 64'hA5A5_0000_0000_0000 + 64'(k)};
        end

        // Twenty idle cycles.
        step(); up_valid = 0;
        repeat (19) step();
        @(negedge clk_wr); chk("idle_word", dout[0], 0);
        step(); up_valid = 1; up_data = 75'h7_0000_0000_0000_0042;
        @(negedge clk_wr); chk("idle_cnt_20", idle[0], 20);

        // Gen2 misconfiguration flag.
        step(); m_gen2_mode = 1;
        step(); m_gen2_mode = 0;
        @(negedge clk_wr); chk("err_gen2_set", err[0], 1);
        repeat (10) step();
        @(negedge clk_wr); chk("err_gen2_hold", err[0], 1);

        // One-cycle link drop with data offered.
        step(); tx_online = 0;
        @(negedge clk_wr); chk("drop_ready", up_ready[0], 0);
        step(); tx_online = 1;
        @(negedge clk_wr); chk("drop_offline", st[0], 0); chk("drop_data", dout[0], 0);
        step();
        @(negedge clk_wr);
        chk("drop_settle", st[0], 1);
        chk("drop_stb_mrk", {stb[0], mrk[0]}, 0);
        repeat (12) step();
        @(negedge clk_wr); chk("reactive", st[0], 3);
        repeat (5) step();

        // Reset while ACTIVE with a word in flight.
        step(); rst_wr_n = 0;
        #1;
        chk("rst_mid_data", dout[1], 0);
        chk("rst_mid_state", st[1], 0);
        chk("rst_mid_ready", up_ready[1], 0);
        chk("rst_mid_stb_mrk", {stb[1], mrk[1]}, 0);
        chk("rst_mid_err", err[0], 0);
        step(); rst_wr_n = 1;
        repeat (3) step();
        @(negedge clk_wr); chk("min_stb_c3", stb[1], 1);
        step();
        @(negedge clk_wr); chk("min_stb_c4", stb[1], 0); chk("min_active_c4", st[1], 3);
        step();
        @(negedge clk_wr); chk("min_stb_c5", stb[1], 1);
        repeat (12) step();

        @(negedge clk_wr);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
